// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse sequencer: FSM states, default
// field width and the per-channel configuration reset values.
package pulse_seq_pkg;

    localparam int CW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [CW_DEFAULT-1:0] high;
        logic [CW_DEFAULT-1:0] low;
        logic [CW_DEFAULT-1:0] count;
    } seq_cfg_t;

    localparam seq_cfg_t CFG_RESET = '{
        high:  CW_DEFAULT'(1),
        low:   CW_DEFAULT'(1),
        count: CW_DEFAULT'(1)
    };

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the first pending channel at or after the pointer wins.
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         pending,
    input  logic [$clog2(N_CH)-1:0] pointer,
    output logic [N_CH-1:0]         winner,
    output logic                    valid
);

    localparam int PW = $clog2(N_CH);

    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = PW'((32'(pointer) + 32'(k)) % N_CH);
            if (!valid && pending[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Shared pulse-train engine: per-channel config, round-robin arbitration and
// one high/low timing counter pair that serves one granted channel at a time.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CW   = CW_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [CW-1:0]           cfg_high,
    input  logic [CW-1:0]           cfg_low,
    input  logic [CW-1:0]           cfg_count,
    input  logic [N_CH-1:0]         req,
    output logic [N_CH-1:0]         grant,
    output logic [N_CH-1:0]         pulse_out,
    output logic [N_CH-1:0]         done,
    output logic                    busy
);

    localparam int PW = $clog2(N_CH);

    logic [CW-1:0]   cfg_high_r  [N_CH];
    logic [CW-1:0]   cfg_low_r   [N_CH];
    logic [CW-1:0]   cfg_count_r [N_CH];

    seq_state_t      state;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] pend_clear;
    logic [N_CH-1:0] arb_winner;
    logic            arb_valid;
    logic [PW-1:0]   pointer;
    logic [PW-1:0]   cur_idx;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   next_ptr;
    logic [CW-1:0]   cur_high;
    logic [CW-1:0]   cur_low;
    logic [CW-1:0]   phase_cnt;
    logic [CW-1:0]   remaining;

    function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
        return (v == '0) ? CW'(1) : v;
    endfunction

    rr_arbiter #(
        .N_CH(N_CH)
    ) u_arb (
        .pending(pending),
        .pointer(pointer),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (arb_winner[i]) win_idx = PW'(i);
        end
    end

    assign pend_clear = (state == IDLE && arb_valid) ? arb_winner : '0;
    assign next_ptr   = (cur_idx == PW'(N_CH - 1)) ? '0 : cur_idx + 1'b1;

    // Config file: the engine samples it only at grant, so a write landing on
    // the grant edge still hands the old values to that train.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cfg_high_r[i]  <= CW'(CFG_RESET.high);
                cfg_low_r[i]   <= CW'(CFG_RESET.low);
                cfg_count_r[i] <= CW'(CFG_RESET.count);
            end
        end else if (cfg_we && (32'(cfg_ch) < N_CH)) begin
            cfg_high_r[cfg_ch]  <= cfg_high;
            cfg_low_r[cfg_ch]   <= cfg_low;
            cfg_count_r[cfg_ch] <= cfg_count;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= '0;
            pulse_out <= '0;
            done      <= '0;
            busy      <= 1'b0;
            pending   <= '0;
            pointer   <= '0;
            cur_idx   <= '0;
            cur_high  <= '0;
            cur_low   <= '0;
            phase_cnt <= '0;
            remaining <= '0;
        end else begin
            pending <= (pending | req) & ~pend_clear;
            done    <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant     <= arb_winner;
                        busy      <= 1'b1;
                        cur_idx   <= win_idx;
                        cur_high  <= at_least_one(cfg_high_r[win_idx]);
                        cur_low   <= at_least_one(cfg_low_r[win_idx]);
                        phase_cnt <= at_least_one(cfg_high_r[win_idx]);
                        remaining <= cfg_count_r[win_idx];
                        pulse_out <= (cfg_count_r[win_idx] == '0) ? '0 : arb_winner;
                        state     <= HIGH;
                    end
                end
                HIGH: begin
                    // A zero-count train holds grant for this one cycle only.
                    if (remaining == '0) begin
                        done      <= grant;
                        grant     <= '0;
                        pulse_out <= '0;
                        pointer   <= next_ptr;
                        state     <= DONE;
                    end else if (phase_cnt == CW'(1)) begin
                        pulse_out <= '0;
                        phase_cnt <= cur_low;
                        state     <= LOW;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                LOW: begin
                    if (phase_cnt == CW'(1)) begin
                        remaining <= remaining - 1'b1;
                        if (remaining > CW'(1)) begin
                            pulse_out <= grant;
                            phase_cnt <= cur_high;
                            state     <= HIGH;
                        end else begin
                            done      <= grant;
                            grant     <= '0;
                            pulse_out <= '0;
                            pointer   <= next_ptr;
                            state     <= DONE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Shared pulse-train engine that generates programmable pulse trains for up to N_CH requesters, one channel at a time. Each channel has its own high-length, low-length and pulse-count settings. Requests are arbitrated round-robin, and one timing counter pair is shared across all channels. It replaces free-running, hand-timed pulse modules with a synthesizable, configurable scheduler on the common clock.

Parameters:
N_CH, 4, number of requesting channels / pulse outputs
CW, 8, width of the length and count fields and of the internal counters

Ports:
clock  input  1  system clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
cfg_we  input  1  config write strobe, sampled on posedge
cfg_ch  input  $clog2(N_CH)  channel selected for a config write
cfg_high  input  CW  high-phase length, in cycles
cfg_low  input  CW  low-phase length, in cycles
cfg_count  input  CW  number of pulses per train
req  input  N_CH  train request per channel (a 1-cycle pulse is sufficient)
grant  output  N_CH  one-hot; the channel currently owning the engine
pulse_out  output  N_CH  pulse trains; only the granted bit may toggle
done  output  N_CH  1-cycle strobe when a channel's train completes
busy  output  1  engine not IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately): grant=0, pulse_out=0, done=0, busy=0, pending=0, rr pointer=0, state=IDLE, all config registers high=1, low=1, count=1.
- Config: on cfg_we, the registers of cfg_ch are written at posedge. Writes are legal at any time. The engine latches a channel's config at grant, so a write to the active channel affects only its next train.
- Request: req[i]=1 at a posedge sets pending[i]. pending[i] clears on the cycle grant[i] rises. A req to an already-pending channel is absorbed.
- Arbitration: round-robin starting at the rr pointer. After a channel completes, the pointer moves to (i+1) mod N_CH.
- FSM states: IDLE, HIGH, LOW, DONE.
  - IDLE: if pending!=0, go to HIGH. grant[winner]=1, busy=1, pulse_out[winner]=1 at the same edge. Latency is req edge + 1 cycle to the first high output.
  - HIGH: pulse_out[g]=1 for exactly max(high,1) cycles, then go to LOW.
  - LOW: pulse_out[g]=0 for max(low,1) cycles. Decrement the remaining count. If remaining>0, go to HIGH; else go to DONE. The final low phase is always emitted.
  - DONE: one cycle. done[g]=1, grant=0, busy=1, pulse_out=0. Advance the rr pointer. Next state is IDLE, so there is one idle cycle minimum between trains.
- count=0: the channel is granted, no pulse is produced, and it goes HIGH-skipped directly to DONE (grant for 1 cycle, then done).
- Length fields of 0 are treated as 1. Counters are CW bits and never wrap. The maximum train is 2^CW-1 pulses.
- Simultaneous events:
  - req[i] in the same cycle as done[i]: pending[i] is set and served in rr order after the other channels.
  - cfg_we together with grant of the same channel: the old config is used.
- reset_n asserted mid-train: outputs drop to 0 asynchronously. No done strobe is issued, and all pending requests are lost.
- Invariant: popcount(grant)<=1, and pulse_out & ~grant == 0.

Decomposition:
- Package pulse_seq_pkg holds:
  - the state enum (IDLE, HIGH, LOW, DONE)
  - the default CW
  - the reset config constants (1,1,1)
  - a config struct {high, low, count}
- Sub-module rr_arbiter (N_CH-wide) has these ports:
  - inputs: pending, pointer
  - outputs: one-hot winner, valid
- The top module holds the config register file, FSM, counters and output registers.

Test Plan:
1. Reset then idle: hold reset_n=0 for 3 cycles, release, no req -> all outputs 0, busy=0 for 20 cycles.
2. Single train: cfg ch0 high=4 low=4 count=3, pulse req[0] -> grant[0] next cycle; pulse_out[0] pattern 4H/4L x3 (24 cycles); done[0] 1 cycle later; grant=0.
3. Round-robin: ch1 (high=2, low=2, count=1) and ch3 (high=1, low=1, count=2) requested in the same cycle, pointer=0 -> ch1 served first, then ch3 after 1 IDLE cycle; pointer ends at 0.
4. Edge configs: ch2 count=0 -> grant[2] for 1 cycle, done[2], no pulse. ch2 high=0 low=0 count=2 -> 1H/1L x2.
5. Config during train: rewrite ch0 high=10 mid-train -> current train keeps high=4; next req[0] produces high=10.
6. Reset mid-train: assert reset_n=0 during the HIGH phase of ch0 -> pulse_out and grant drop within the same cycle, no done, pending cleared after release.
